// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: free-run / single-step / halt.
// Ports: clk, rst, clk_cpu_in, run_sw, step_btn, halt -> cpu_en, cycle_cnt, mode.
module cpu_clk_ctrl #(
  parameter logic [31:0] DEBOUNCE_CYCLES = 32'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_cpu_in,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        halt,
  output logic        cpu_en,
  output logic [31:0] cycle_cnt,
  output logic [1:0]  mode
);

  typedef enum logic [1:0] {
    STOP      = 2'b00,
    RUN       = 2'b01,
    STEP_WAIT = 2'b10,
    HALTED    = 2'b11
  } state_t;

  state_t state, state_n;

  logic run_q1, run_s;
  logic step_q1, step_s;
  logic [31:0] db_cnt;
  logic step_db, step_db_q;
  logic [1:0] sync_vld;
  logic armed;
  logic clk_hist;
  logic step_req, tick;
  logic en_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q1  <= 1'b0;
      run_s   <= 1'b0;
      step_q1 <= 1'b0;
      step_s  <= 1'b0;
    end else begin
      run_q1  <= run_sw;
      run_s   <= run_q1;
      step_q1 <= step_btn;
      step_s  <= step_q1;
    end
  end

  // armed: a press only counts once the button has been
  // seen released after reset, so a button held through
  // reset never yields a step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt    <= '0;
      step_db   <= 1'b0;
      step_db_q <= 1'b0;
      sync_vld  <= '0;
      armed     <= 1'b0;
    end else begin
      step_db_q <= step_db;
      sync_vld  <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && !step_s && !step_db)
        armed <= 1'b1;
      if (step_s == step_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DEBOUNCE_CYCLES - 32'd1) begin
        step_db <= step_s;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) clk_hist <= 1'b0;
    else     clk_hist <= clk_cpu_in;
  end

  assign step_req = step_db & ~step_db_q & armed;
  assign tick     = clk_cpu_in & ~clk_hist;

  always_comb begin
    state_n = state;
    en_n    = 1'b0;
    unique case (state)
      STOP: begin
        if (step_req) begin
          en_n    = 1'b1;
          state_n = STEP_WAIT;
        end else if (run_s) begin
          state_n = RUN;
        end
      end
      STEP_WAIT: begin
        if (!step_db) state_n = STOP;
      end
      RUN: begin
        if (!run_s) state_n = STOP;
        else        en_n    = tick;
      end
      HALTED: begin
        if (!halt && !run_s) state_n = STOP;
      end
      default: state_n = STOP;
    endcase
    if (halt) begin
      state_n = HALTED;
      en_n    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= STOP;
      cpu_en <= 1'b0;
    end else begin
      state  <= state_n;
      cpu_en <= en_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cycle_cnt <= '0;
    else if (cpu_en) cycle_cnt <= cycle_cnt + 32'd1;
  end

  assign mode = state;

endmodule

// File: doc/cpu_clk_ctrl.md
CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 32'd1000000, SHALL set the number of consecutive stable clk cycles required to accept a step_btn level change.
REQ-002 Port clk, input, 1, system clock; the only clock in the block.
REQ-003 Port rst, input, 1, asynchronous active-high reset.
REQ-004 Port clk_cpu_in, input, 1, prescaled CPU clock level from the clock prescaler, registered in the clk domain.
REQ-005 Port run_sw, input, 1, asynchronous slide switch: 1 = free-run, 0 = single-step.
REQ-006 Port step_btn, input, 1, asynchronous active-high pushbutton, bouncy.
REQ-007 Port halt, input, 1, synchronous CPU halt request, level.
REQ-008 Port cpu_en, output, 1, registered one-clk CPU clock-enable pulse.
REQ-009 Port cycle_cnt, output, 32, count of cpu_en pulses issued.
REQ-010 Port mode, output, 2, current state encoding: STOP=00, RUN=01, STEP_WAIT=10, HALTED=11.

Function
REQ-011 run_sw and step_btn SHALL each pass through a 2-flop synchronizer (run_s, step_s) before any use.
REQ-012 Debounce: a 32-bit counter SHALL clear whenever step_s equals the debounced level step_db, otherwise increment; when it reaches DEBOUNCE_CYCLES-1, step_db SHALL take step_s and the counter SHALL clear.
REQ-013 step_req SHALL be a one-clk pulse on a 0->1 transition of step_db.
REQ-014 tick SHALL be a one-clk pulse: clk_cpu_in high while its previous-cycle registered value is low.
REQ-015 halt SHALL have priority in every state: halt=1 forces next state HALTED and suppresses cpu_en that cycle.
REQ-016 STOP: step_req -> cpu_en pulse, next STEP_WAIT; else run_s=1 -> RUN; tick ignored.
REQ-017 STEP_WAIT: no cpu_en; step_db=0 -> STOP; run_s is ignored until STOP is reached.
REQ-018 RUN: cpu_en <= tick; run_s=0 -> STOP, and a tick in that same cycle SHALL NOT produce cpu_en.
REQ-019 HALTED: no cpu_en; halt=0 and run_s=0 -> STOP; otherwise remain.
REQ-020 cpu_en SHALL be registered: high for exactly one clk, in the cycle after the clk edge where tick or step_req was asserted.
REQ-021 Step latency SHALL be between DEBOUNCE_CYCLES and DEBOUNCE_CYCLES+4 clks, measured from step_btn stable high to cpu_en.
REQ-022 Bounces on step_btn shorter than DEBOUNCE_CYCLES SHALL produce no step_req.
REQ-023 cycle_cnt SHALL increment by 1 in the cycle cpu_en is high, and SHALL wrap from 32'hFFFFFFFF to 0.
REQ-024 At most one cpu_en pulse SHALL be issued per button press, regardless of hold time.

Reset
REQ-025 rst=1 SHALL immediately force: cpu_en=0, cycle_cnt=0, mode=STOP, synchronizers=0, step_db=0, debounce counter=0, clk_cpu_in history=0.
REQ-026 Reset asserted mid-debounce or mid-STEP_WAIT SHALL discard the pending press; no cpu_en is issued after release of reset unless a new press is made.
REQ-027 The first clk_cpu_in high after reset SHALL count as a tick (history resets to 0).

Verification
REQ-028 DEBOUNCE_CYCLES=4, run_sw=1, clk_cpu_in toggling with period 8 clk -> mode=01; one cpu_en per rising edge, one clk after it; cycle_cnt=3 after 3 rising edges.
REQ-029 run_sw=0, step_btn high for 20 clk -> exactly one cpu_en, 4 to 8 clk after the press; mode sequence 00->10->00 after release; cycle_cnt=1.
REQ-030 run_sw=0, step_btn toggling every 2 clk for 16 clk, then low -> no cpu_en; cycle_cnt=0.
REQ-031 RUN with halt=1 coinciding with a tick -> no cpu_en; mode=11; with run_sw=1 it stays 11 after halt=0; setting run_sw=0 -> mode=00.
REQ-032 cycle_cnt preset via force to 32'hFFFFFFFF, then one step -> cycle_cnt=0.
REQ-033 rst pulsed during STEP_WAIT with step_btn still held -> mode=00 and cpu_en=0 immediately; no cpu_en until the button is released and pressed again.
